// File: rtl/sync_pulse_tx.sv
// RF shutter-glasses transmitter: on each synchronised vsync rise, serialises a 6-bit-period
// frame (start burst, gap, Manchester eye bit, stop) onto rf_data; 2-cycle sync + 1 accept latency.
module sync_pulse_tx #(
   parameter int BIT_CYCLES  = 6000,
   parameter int TIMER_WIDTH = 13
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync,
   input  logic       lr_sel,
   input  logic       enable,
   output logic       rf_data,
   output logic       busy,
   output logic       overrun,
   output logic [7:0] frame_cnt
);

   typedef enum logic [2:0] {IDLE, START, GAP, EYE_A, EYE_B, STOP} state_t;

   localparam logic [TIMER_WIDTH-1:0] LAST = TIMER_WIDTH'(BIT_CYCLES - 1);

   state_t                 state, state_nxt;
   logic [TIMER_WIDTH-1:0] timer, timer_nxt;
   logic                   sub, sub_nxt;
   logic                   eye, eye_nxt;
   logic                   rf_nxt, busy_nxt, ovr_nxt;
   logic [7:0]             cnt_nxt;
   logic                   vs_s1, vs_s2, vs_s3, lr_s1, lr_s2;
   logic                   vs_rise, bit_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_s1 <= 1'b0;
         vs_s2 <= 1'b0;
         vs_s3 <= 1'b0;
         lr_s1 <= 1'b0;
         lr_s2 <= 1'b0;
      end else begin
         vs_s1 <= vsync;
         vs_s2 <= vs_s1;
         vs_s3 <= vs_s2;
         lr_s1 <= lr_sel;
         lr_s2 <= lr_s1;
      end
   end

   assign vs_rise = vs_s2 & ~vs_s3;
   assign bit_end = (timer == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         sub       <= 1'b0;
         eye       <= 1'b0;
         rf_data   <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         sub       <= sub_nxt;
         eye       <= eye_nxt;
         rf_data   <= rf_nxt;
         busy      <= busy_nxt;
         overrun   <= ovr_nxt;
         frame_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = '0;
      sub_nxt   = sub;
      eye_nxt   = eye;
      cnt_nxt   = frame_cnt;
      ovr_nxt   = vs_rise && (state != IDLE);
      if (state != IDLE)
         timer_nxt = bit_end ? '0 : timer + 1'b1;

      case (state)
         IDLE: begin
            sub_nxt = 1'b0;
            if (vs_rise && enable) begin
               state_nxt = START;
               eye_nxt   = lr_s2;
               cnt_nxt   = frame_cnt + 8'd1;
            end
         end
         // START spans two bit periods; sub marks the second one
         START: if (bit_end) begin
            if (sub) begin
               state_nxt = GAP;
               sub_nxt   = 1'b0;
            end else begin
               sub_nxt   = 1'b1;
            end
         end
         GAP:     if (bit_end) state_nxt = EYE_A;
         EYE_A:   if (bit_end) state_nxt = EYE_B;
         EYE_B:   if (bit_end) state_nxt = STOP;
         STOP:    if (bit_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // outputs are registered, so they are decoded from the state being entered
      case (state_nxt)
         START:   rf_nxt = 1'b1;
         EYE_A:   rf_nxt = eye_nxt;
         EYE_B:   rf_nxt = ~eye_nxt;
         default: rf_nxt = 1'b0;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_sync_pulse_tx.sv
// Scoreboard bench for sync_pulse_tx: stimulus queues per-cycle expected frames, monitor checks.
module tb_sync_pulse_tx;

   localparam int BC = 4;
   localparam int FRAME = 6 * BC;

   logic       clk = 1'b0;
   logic       rst_n, vsync, lr_sel, enable;
   logic       rf_data, busy, overrun;
   logic [7:0] frame_cnt;

   typedef struct {
      logic       rf;
      logic [7:0] cnt;
   } exp_t;

   exp_t       exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         ovr_seen = 0;
   logic [7:0] cnt_model = 8'd0;

   sync_pulse_tx #(.BIT_CYCLES(BC), .TIMER_WIDTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .vsync(vsync), .lr_sel(lr_sel), .enable(enable),
      .rf_data(rf_data), .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every busy cycle must match the next queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (overrun) ovr_seen++;
            if (busy) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_busy: got busy=1 expected busy=0 at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("rf_data", rf_data, e.rf);
                  chk("frame_cnt", frame_cnt, e.cnt);
               end
            end else begin
               chk("idle_rf", rf_data, 1'b0);
            end
         end
      end
   end

   task automatic push_frame(input logic lr);
      logic [5:0] pat;
      exp_t e;
      pat = lr ? 6'b110100 : 6'b110010;
      cnt_model = cnt_model + 8'd1;
      for (int i = 0; i < FRAME; i++) begin
         e.rf  = pat[5 - i / BC];
         e.cnt = cnt_model;
         exp_q.push_back(e);
      end
   endtask

   // Raises vsync before e0; returns at the negedge after e2 (first busy cycle).
   task automatic start_frame(input logic lr);
      push_frame(lr);
      lr_sel = lr;
      vsync  = 1'b1;
      @(negedge clk);
      chk("lat_e0_busy", busy, 1'b0);
      @(negedge clk);
      chk("lat_e1_rf", {rf_data, busy}, 2'b00);
      @(negedge clk);
      chk("lat_e2_rf", {rf_data, busy}, 2'b11);
      vsync = 1'b0;
   endtask

   task automatic phase_check(input string name, input int exp_ovr);
      chk({name, "_frames_done"}, exp_q.size(), 0);
      chk({name, "_overruns"}, ovr_seen, exp_ovr);
      ovr_seen = 0;
   endtask

   initial begin
      rst_n  = 1'b0;
      vsync  = 1'b0;
      lr_sel = 1'b0;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outs", {rf_data, busy, overrun, frame_cnt}, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_outs", {rf_data, busy, overrun, frame_cnt}, 0);
      end

      // Left frame
      start_frame(1'b1);
      repeat (30) @(negedge clk);
      phase_check("left", 0);
      chk("left_cnt", frame_cnt, 8'd1);

      // Right frame, lr_sel toggling mid-frame
      start_frame(1'b0);
      fork
         begin
            repeat (8) begin
               repeat (3) @(negedge clk);
               lr_sel = ~lr_sel;
            end
         end
      join_none
      repeat (30) @(negedge clk);
      phase_check("right_toggle", 0);

      // Overrun 10 cycles into a frame
      start_frame(1'b1);
      repeat (8) @(negedge clk);
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      vsync = 1'b0;
      repeat (30) @(negedge clk);
      phase_check("overrun_mid", 1);
      chk("overrun_cnt", frame_cnt, cnt_model);

      // Edge seen on the final STOP cycle is discarded
      start_frame(1'b0);
      repeat (21) @(negedge clk);
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      vsync = 1'b0;
      repeat (20) @(negedge clk);
      phase_check("overrun_stop", 1);

      // Edge seen on the first IDLE cycle after STOP is accepted
      start_frame(1'b1);
      repeat (22) @(negedge clk);
      push_frame(1'b0);
      lr_sel = 1'b0;
      vsync  = 1'b1;
      repeat (3) @(negedge clk);
      vsync = 1'b0;
      repeat (40) @(negedge clk);
      phase_check("back_to_back", 0);

      // Enable low at vsync rise: ignored silently
      enable = 1'b0;
      vsync  = 1'b1;
      repeat (3) @(negedge clk);
      vsync = 1'b0;
      repeat (30) @(negedge clk);
      phase_check("enable_low", 0);
      chk("enable_low_cnt", frame_cnt, cnt_model);
      enable = 1'b1;

      // Enable dropped mid-frame: frame completes
      start_frame(1'b1);
      repeat (4) @(negedge clk);
      enable = 1'b0;
      repeat (30) @(negedge clk);
      phase_check("enable_drop", 0);
      enable = 1'b1;

      // Asynchronous reset at cycle 14 of a frame
      start_frame(1'b0);
      repeat (13) @(negedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      cnt_model = 8'd0;
      #1 chk("async_reset", {rf_data, busy, overrun, frame_cnt}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ovr_seen = 0;
      repeat (3) @(negedge clk);
      start_frame(1'b1);
      repeat (30) @(negedge clk);
      phase_check("after_reset", 0);
      chk("after_reset_cnt", frame_cnt, 8'd1);

      // 255 more frames: 256 since reset, counter wraps to 0
      for (int i = 0; i < 255; i++) begin
         start_frame(logic'(i[0]));
         repeat (26) @(negedge clk);
      end
      phase_check("wrap", 0);
      chk("wrap_cnt", frame_cnt, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_pulse_tx.md
Name: sync_pulse_tx

Overview:
- Transmitter end of the RF shutter-glasses link. It sits on the display/emitter side, downstream of the display's vsync and stereo-eye signals.
- On each vsync rising edge it serialises one fixed-length frame onto `rf_data`, which drives the OOK RF module's data pin.
- The frame carries a start burst and a Manchester-coded eye bit that the glasses receiver decodes.

Parameters:
- BIT_CYCLES, 6000, clk cycles per bit period (12 MHz clk -> 500 us/bit); legal range 2..2^TIMER_WIDTH-1.
- TIMER_WIDTH, 13, width of the bit-period timer.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- vsync  input  1  display vertical sync, asynchronous to clk; active high.
- lr_sel  input  1  eye of the frame that is starting (1 = left, 0 = right); asynchronous, sampled at the accepted edge.
- enable  input  1  when low, new frames are not started.
- rf_data  output  1  serial OOK data to the RF module; registered.
- busy  output  1  high while a frame is in progress.
- overrun  output  1  one-cycle pulse when a vsync edge is discarded.
- frame_cnt  output  8  count of accepted frames.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). rst_n low forces the following, regardless of mid-frame state:
  - state = IDLE
  - rf_data = 0, busy = 0, overrun = 0, frame_cnt = 0
  - timer = 0, sync flops = 0, latched eye = 0
- Input sync: vsync and lr_sel each pass through a 2-flop synchroniser. A third flop on vsync forms the rising-edge detector, `vs_rise = sync2 & ~sync3`.
- Accept: a frame is accepted when `vs_rise` is high, state == IDLE and enable == 1. On the accepting edge:
  - state <= START, rf_data <= 1, busy <= 1
  - eye <= synchronised lr_sel
  - timer <= 0
  - frame_cnt <= frame_cnt + 1 (mod 256; 255 wraps to 0)
- Latency: if e0 is the first clk edge that samples vsync high, rf_data and busy are high after e2.
- Bit timer:
  - Counts 0..BIT_CYCLES-1 in every non-IDLE state.
  - `bit_end` = (timer == BIT_CYCLES-1); on bit_end the timer wraps to 0.
  - Held at 0 in IDLE.
- FSM: each state advances on bit_end; rf_data is registered per state.
  - START: 2 bit periods, rf_data = 1. A 1-bit sub-counter selects the second period.
  - GAP: 1 bit period, rf_data = 0.
  - EYE_A: 1 bit period, rf_data = eye.
  - EYE_B: 1 bit period, rf_data = ~eye.
  - STOP: 1 bit period, rf_data = 0; then IDLE with busy = 0 on the same edge.
  - Frame length is exactly 6*BIT_CYCLES cycles of busy high.
  - Left eye waveform: 1,1,0,1,0,0 (in bit periods). Right eye waveform: 1,1,0,0,1,0.
- Eye stability: eye is latched at acceptance; lr_sel changes mid-frame have no effect.
- enable:
  - Sampled only at acceptance.
  - Deasserting enable mid-frame does not abort the frame; it completes normally.
  - A vs_rise in IDLE with enable low is ignored silently (no overrun, no count).
- Overrun: vs_rise while state != IDLE gives overrun = 1 for exactly one cycle, and the edge is discarded.
  - This includes an edge on the final STOP cycle.
  - An edge on the first IDLE cycle after STOP is accepted.
- Sustained vsync: a vsync held high produces only one frame; re-arming needs a low level seen by the synchroniser.
- rf_data is 0 whenever in IDLE.

Test Plan (BIT_CYCLES=4, TIMER_WIDTH=3; frame = 24 cycles):
- Reset then idle: rst_n low 3 cycles then high, vsync = 0 -> rf_data = busy = overrun = 0 and frame_cnt = 0 for 50 cycles.
- Left frame: lr_sel = 1, enable = 1, vsync rises before e0 -> rf_data high after e2 and the per-cycle pattern is 1×8, 0×4, 1×4, 0×4, 0×4. busy is high for exactly 24 cycles and frame_cnt = 1.
- Right frame with lr_sel toggled mid-frame: lr_sel = 0 at the edge, toggles every 3 cycles -> pattern is 1×8, 0×4, 0×4, 1×4, 0×4 unchanged.
- Overrun: second vsync rise 10 cycles into a frame -> overrun is high for 1 cycle, the frame completes as 24 cycles, frame_cnt increments only once, and no second frame follows.
- Enable gating:
  - enable = 0 at a vsync rise -> no frame and no overrun.
  - enable dropped at cycle 5 of a frame -> the full 24-cycle frame still completes.
- Reset mid-frame and wrap:
  - rst_n pulsed low at cycle 14 of a frame -> rf_data, busy and frame_cnt are 0 immediately (asynchronous); the next vsync gives a clean full frame.
  - 256 accepted frames -> frame_cnt wraps to 0.
